// File: rtl/ntt_host_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_host_ctrl_if
//  Description : Bundles the host word stream, coefficient-memory port,
//                NTT core start/done handshake, UART TX byte handshake and
//                status flags of ntt_host_ctrl.
//                master : the controller side (ntt_host_ctrl)
//                slave  : the surrounding system (assembler, RAM, core, TX)
//  Ports       : word_data_i/word_addr_i/word_valid_i/load_done_i  host stream
//                mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i        RAM port
//                ntt_start_o/ntt_done_i                             core
//                tx_byte_o/tx_valid_o/tx_ready_i                    UART TX
//                busy_o/err_o                                       status
//  Revision    : 1.0  initial release
// ============================================================================
interface ntt_host_ctrl_if #(
    parameter int AW = 8
) ();
    logic [31:0]   word_data_i;
    logic [31:0]   word_addr_i;
    logic          word_valid_i;
    logic          load_done_i;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;
    logic          ntt_start_o;
    logic          ntt_done_i;
    logic [7:0]    tx_byte_o;
    logic          tx_valid_o;
    logic          tx_ready_i;
    logic          busy_o;
    logic          err_o;

    modport master (
        input  word_data_i, word_addr_i, word_valid_i, load_done_i,
               mem_rdata_i, ntt_done_i, tx_ready_i,
        output mem_we_o, mem_addr_o, mem_wdata_o, ntt_start_o,
               tx_byte_o, tx_valid_o, busy_o, err_o
    );

    modport slave (
        output word_data_i, word_addr_i, word_valid_i, load_done_i,
               mem_rdata_i, ntt_done_i, tx_ready_i,
        input  mem_we_o, mem_addr_o, mem_wdata_o, ntt_start_o,
               tx_byte_o, tx_valid_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/ntt_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_host_ctrl
//  Description : Runs one host-driven NTT job: stores incoming coefficient
//                words in RAM, pulses the core start, waits for completion,
//                then reads every result word back and streams it to the
//                UART transmitter as four little-endian bytes.
//  Parameters  : N  - coefficients per job (power of two)
//                AW - memory address width, log2(N)
//  Ports       : clk_i  - system clock, rising edge
//                rst_i  - synchronous active-high reset
//                bus    - ntt_host_ctrl_if.master (host stream, RAM port,
//                         core handshake, TX byte handshake, busy/err)
//  Options     : NTT_CTRL_CHECKSUM_EN - when defined, one extra word holding
//                the XOR of all result words is sent after the last result.
//  Revision    : 1.0  initial release
// ============================================================================
module ntt_host_ctrl #(
    parameter int N  = 256,
    parameter int AW = 8
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    ntt_host_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_WAIT    = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_SEND    = 3'd6,
        S_FINISH  = 3'd7
    } state_t;

    // Read index is one bit wider than the address so N itself is
    // representable (used as the "checksum word" marker).
    localparam logic [AW:0] C_N    = (AW+1)'(N);
    localparam logic [AW:0] C_LAST = (AW+1)'(N - 1);
    localparam logic [AW:0] C_ONE  = (AW+1)'(1);

    state_t        state_q,     state_d;
    logic [AW:0]   load_cnt_q,  load_cnt_d;
    logic [AW:0]   rd_idx_q,    rd_idx_d;
    logic [1:0]    byte_idx_q,  byte_idx_d;
    logic [31:0]   shift_q,     shift_d;
    logic          mem_we_q,    mem_we_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          err_q,       err_d;
`ifdef NTT_CTRL_CHECKSUM_EN
    logic [31:0]   csum_q,      csum_d;
`endif

    logic          w_addr_ok;
    logic          w_load_phase;
    logic [AW:0]   w_rd_next;

    assign w_addr_ok    = (bus.word_addr_i[31:AW] == '0);
    assign w_load_phase = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign w_rd_next    = rd_idx_q + C_ONE;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            load_cnt_q  <= '0;
            rd_idx_q    <= '0;
            byte_idx_q  <= '0;
            shift_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_q       <= 1'b0;
`ifdef NTT_CTRL_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            rd_idx_q    <= rd_idx_d;
            byte_idx_q  <= byte_idx_d;
            shift_q     <= shift_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_q       <= err_d;
`ifdef NTT_CTRL_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        rd_idx_d    = rd_idx_q;
        byte_idx_d  = byte_idx_q;
        shift_d     = shift_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = err_q;
`ifdef NTT_CTRL_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        // Host words are accepted in IDLE and LOAD alike; this also covers
        // a strobe that coincides with load_done_i. Anywhere else the strobe
        // is a protocol error and the port is left untouched.
        if (bus.word_valid_i) begin
            if (w_load_phase) begin
                if (w_addr_ok) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = bus.word_addr_i[AW-1:0];
                    mem_wdata_d = bus.word_data_i;
                end else begin
                    err_d = 1'b1;
                end
                if (load_cnt_q != C_N) begin
                    load_cnt_d = load_cnt_q + C_ONE;
                end
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // load_done_i alone is ignored here: nothing has arrived yet.
                if (bus.word_valid_i) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (bus.load_done_i) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.ntt_done_i) begin
                    rd_idx_d   = '0;
                    mem_addr_d = '0;
`ifdef NTT_CTRL_CHECKSUM_EN
                    csum_d     = '0;
`endif
                    state_d    = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                // Address already registered on entry; RAM answers next cycle.
                state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                shift_d    = bus.mem_rdata_i;
                byte_idx_d = 2'd0;
`ifdef NTT_CTRL_CHECKSUM_EN
                csum_d     = csum_q ^ bus.mem_rdata_i;
`endif
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (bus.tx_ready_i) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
`ifdef NTT_CTRL_CHECKSUM_EN
                        if (rd_idx_q == C_N) begin
                            state_d = S_FINISH;
                        end else if (rd_idx_q == C_LAST) begin
                            // rd_idx == N marks the checksum word in flight.
                            rd_idx_d   = C_N;
                            shift_d    = csum_q;
                            byte_idx_d = 2'd0;
                            state_d    = S_SEND;
                        end else begin
                            rd_idx_d   = w_rd_next;
                            mem_addr_d = w_rd_next[AW-1:0];
                            state_d    = S_RD_ADDR;
                        end
`else
                        if (rd_idx_q == C_LAST) begin
                            state_d = S_FINISH;
                        end else begin
                            rd_idx_d   = w_rd_next;
                            mem_addr_d = w_rd_next[AW-1:0];
                            state_d    = S_RD_ADDR;
                        end
`endif
                    end
                end
            end
            S_FINISH: begin
                state_d = S_FINISH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.ntt_start_o = (state_q == S_START);
    assign bus.tx_valid_o  = (state_q == S_SEND);
    assign bus.tx_byte_o   = shift_q[{byte_idx_q, 3'b000} +: 8];
    assign bus.busy_o      = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign bus.err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ntt_host_ctrl
//  Description : Self-checking bench for ntt_host_ctrl (N=8 build). Holds a
//                RAM/core model and an array of expected memory contents;
//                result bytes are predicted from that array.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ntt_host_ctrl;

    localparam int TN  = 8;
    localparam int TAW = 3;
`ifdef NTT_CTRL_CHECKSUM_EN
    localparam int EXP_RB_CYC = 6 * TN + 4;
`else
    localparam int EXP_RB_CYC = 6 * TN;
`endif

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    ntt_host_ctrl_if #(.AW(TAW)) bus ();

    ntt_host_ctrl #(.N(TN), .AW(TAW)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.master)
    );

    // ---------------- environment: RAM + core model ----------------
    logic        init_mem;
    logic        core_apply;
    logic        cnt_clr;
    logic [31:0] mem [TN];
    int          we_cnt;
    int          start_cnt;

    always @(posedge clk_i) begin
        if (init_mem) begin
            for (int i = 0; i < TN; i++) mem[i] <= 32'hA5A50000 | i;
        end else if (core_apply) begin
            for (int i = 0; i < TN; i++) mem[i] <= mem[i] + 32'd1;
        end else if (bus.mem_we_o) begin
            mem[bus.mem_addr_o] <= bus.mem_wdata_o;
        end
        bus.mem_rdata_i <= mem[bus.mem_addr_o];
    end

    always @(posedge clk_i) begin
        if (cnt_clr) begin
            we_cnt    <= 0;
            start_cnt <= 0;
        end else begin
            if (bus.mem_we_o)    we_cnt    <= we_cnt + 1;
            if (bus.ntt_start_o) start_cnt <= start_cnt + 1;
        end
    end

    // ---------------- reference state ----------------
    logic [31:0] exp_mem [TN];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];
    int          total = 0;
    int          bad   = 0;

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle;
        step;
        check("idle_no_write", 32'(bus.mem_we_o), 32'd0);
    endtask

    task automatic send_word(input logic [31:0] a, input logic [31:0] d, input bit with_done);
        bus.word_addr_i  = a;
        bus.word_data_i  = d;
        bus.word_valid_i = 1'b1;
        bus.load_done_i  = with_done;
        step;
        bus.word_valid_i = 1'b0;
        bus.load_done_i  = 1'b0;
        if (a < TN) begin
            check("wr_we",   32'(bus.mem_we_o), 32'd1);
            check("wr_addr", 32'(bus.mem_addr_o), a);
            check("wr_data", bus.mem_wdata_o, d);
            exp_mem[a[TAW-1:0]] = d;
        end else begin
            check("oor_no_we", 32'(bus.mem_we_o), 32'd0);
            check("oor_err",   32'(bus.err_o), 32'd1);
        end
        check("start_pulse", 32'(bus.ntt_start_o), 32'(with_done));
    endtask

    task automatic build_expected;
        exp_q.delete();
        for (int i = 0; i < TN; i++)
            for (int b = 0; b < 4; b++) exp_q.push_back(exp_mem[i][8*b +: 8]);
`ifdef NTT_CTRL_CHECKSUM_EN
        begin
            logic [31:0] ck;
            ck = 32'd0;
            for (int i = 0; i < TN; i++) ck ^= exp_mem[i];
            for (int b = 0; b < 4; b++) exp_q.push_back(ck[8*b +: 8]);
        end
`endif
    endtask

    // Idle in WAIT a few cycles, let the core model transform RAM, then done.
    task automatic run_core;
        int k;
        step;
        check("after_start_low", 32'(bus.ntt_start_o), 32'd0);
        k = $urandom_range(1, 4);
        for (int i = 0; i < k; i++) begin
            check("wait_busy",  32'(bus.busy_o), 32'd1);
            check("wait_no_we", 32'(bus.mem_we_o), 32'd0);
            step;
        end
        core_apply = 1'b1;
        step;
        core_apply = 1'b0;
        for (int i = 0; i < TN; i++) exp_mem[i] = exp_mem[i] + 32'd1;
        bus.ntt_done_i = 1'b1;
        step;
        bus.ntt_done_i = 1'b0;
        build_expected();
    endtask

    task automatic readback(input bit rnd, input int bp_byte, input int abort_at,
                            output int cyc, output bit aborted);
        int         nacc;
        int         hold;
        bit         pend;
        logic [7:0] held;
        nacc = 0; hold = 0; pend = 1'b0; held = 8'd0; cyc = 0; aborted = 1'b0;
        got_q.delete();
        while (bus.busy_o === 1'b1 && cyc < 4000) begin
            if (pend) begin
                check("tx_hold_valid", 32'(bus.tx_valid_o), 32'd1);
                check("tx_hold_byte",  32'(bus.tx_byte_o), 32'(held));
            end
            if (bus.tx_valid_o === 1'b1 && nacc == abort_at) begin
                aborted = 1'b1;
                return;
            end
            bus.tx_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (bus.tx_valid_o === 1'b1) begin
                if (nacc == bp_byte && hold < 5) begin
                    bus.tx_ready_i = 1'b0;
                    hold++;
                end
                if (bus.tx_ready_i) begin
                    check("tx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("tx_byte", 32'(bus.tx_byte_o), 32'(exp_q.pop_front()));
                    got_q.push_back(bus.tx_byte_o);
                    nacc++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    held = bus.tx_byte_o;
                end
            end
            step;
            cyc++;
        end
        bus.tx_ready_i = 1'b0;
        check("readback_in_time", 32'(cyc < 4000), 32'd1);
        check("all_bytes_sent",   32'(exp_q.size()), 32'd0);
        check("finish_not_busy",  32'(bus.busy_o), 32'd0);
        check("finish_no_valid",  32'(bus.tx_valid_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},    32'(bus.mem_we_o), 32'd0);
        check({tag, "_addr"},  32'(bus.mem_addr_o), 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata_o, 32'd0);
        check({tag, "_start"}, 32'(bus.ntt_start_o), 32'd0);
        check({tag, "_valid"}, 32'(bus.tx_valid_o), 32'd0);
        check({tag, "_byte"},  32'(bus.tx_byte_o), 32'd0);
        check({tag, "_busy"},  32'(bus.busy_o), 32'd0);
        check({tag, "_err"},   32'(bus.err_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          ab;
        logic [31:0] d;
        int          order [TN];

        rst_i = 1'b1;
        init_mem = 1'b1; core_apply = 1'b0; cnt_clr = 1'b1;
        bus.word_data_i = '0; bus.word_addr_i = '0; bus.word_valid_i = 1'b0;
        bus.load_done_i = 1'b0; bus.ntt_done_i = 1'b0; bus.tx_ready_i = 1'b0;
        for (int i = 0; i < TN; i++) exp_mem[i] = 32'hA5A50000 | i;
        step; step; step;
        init_mem = 1'b0;
        check_reset_outputs("reset");
        rst_i = 1'b0;
        cnt_clr = 1'b0;

        // load_done with nothing loaded: stays idle
        bus.load_done_i = 1'b1;
        step;
        bus.load_done_i = 1'b0;
        check("idle_done_ignored_busy",  32'(bus.busy_o), 32'd0);
        check("idle_done_ignored_start", 32'(bus.ntt_start_o), 32'd0);
        idle_cycle();

        // ---- job 1: addr i, data 0x11110000+i, one out-of-range word ----
        for (int i = 0; i < TN; i++) begin
            send_word(i, 32'h11110000 + i, i == TN - 1);
            if (i == 3) send_word(TN, $urandom, 1'b0);
            if (i < TN - 1) repeat ($urandom_range(0, 2)) idle_cycle();
        end
        run_core();
        check("job1_write_count", 32'(we_cnt), TN);
        check("job1_start_count", 32'(start_cnt), 32'd1);
        readback(1'b1, 2, -1, cyc, ab);
        check("job1_b0", 32'(got_q[0]), 32'h01);
        check("job1_b1", 32'(got_q[1]), 32'h00);
        check("job1_b2", 32'(got_q[2]), 32'h11);
        check("job1_b3", 32'(got_q[3]), 32'h11);
        check("job1_err_sticky", 32'(bus.err_o), 32'd1);

        // ---- job 2: partial random load, aborted by reset mid-send ----
        rst_i = 1'b1;
        step;
        rst_i = 1'b0;
        check("rst_clears_err", 32'(bus.err_o), 32'd0);
        for (int i = 0; i < 5; i++) begin
            send_word($urandom_range(0, TN - 1), $urandom, i == 4);
            if (i < 4) repeat ($urandom_range(0, 1)) idle_cycle();
        end
        step;
        check("after_start_low_j2", 32'(bus.ntt_start_o), 32'd0);
        // stray strobe while waiting on the core
        bus.word_addr_i = 32'd1; bus.word_data_i = 32'hDEADBEEF; bus.word_valid_i = 1'b1;
        step;
        bus.word_valid_i = 1'b0;
        check("stray_word_err", 32'(bus.err_o), 32'd1);
        check("stray_word_no_we", 32'(bus.mem_we_o), 32'd0);
        run_core();
        readback(1'b1, -1, 13, cyc, ab);
        check("job2_aborted", 32'(ab), 32'd1);
        rst_i = 1'b1;
        step;
        check_reset_outputs("midsend_rst");
        rst_i = 1'b0;
        bus.tx_ready_i = 1'b0;

        // ---- job 3: full load in random order, ready tied high ----
        for (int i = 0; i < TN; i++) order[i] = i;
        for (int i = TN - 1; i > 0; i--) begin
            int j;
            int t;
            j = $urandom_range(0, i);
            t = order[i]; order[i] = order[j]; order[j] = t;
        end
        for (int i = 0; i < TN; i++) begin
`ifdef NTT_CTRL_CHECKSUM_EN
            d = (32'd1 << order[i]) - 32'd1;
`else
            d = $urandom;
`endif
            send_word(order[i], d, i == TN - 1);
        end
        run_core();
        readback(1'b0, -1, -1, cyc, ab);
        check("job3_readback_cycles", 32'(cyc), EXP_RB_CYC);
`ifdef NTT_CTRL_CHECKSUM_EN
        check("csum_b0", 32'(got_q[32]), 32'hFF);
        check("csum_b1", 32'(got_q[33]), 32'h00);
        check("csum_b2", 32'(got_q[34]), 32'h00);
        check("csum_b3", 32'(got_q[35]), 32'h00);
`endif
        // strobe in FINISH is ignored but flagged
        check("finish_err_clear", 32'(bus.err_o), 32'd0);
        bus.word_addr_i = 32'd0; bus.word_valid_i = 1'b1;
        step;
        bus.word_valid_i = 1'b0;
        check("finish_word_err", 32'(bus.err_o), 32'd1);
        check("finish_word_no_we", 32'(bus.mem_we_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ntt_host_ctrl.md
# ntt_host_ctrl

Sequences one complete host-driven NTT job: it writes the coefficient words delivered by the UART word assembler into coefficient RAM, pulses the NTT core start, waits for core completion, then reads the result RAM back and streams it to the UART transmitter as bytes. It sits between the UART receive/assemble path, the NTT core with its coefficient memory, and the UART TX byte interface, and is the only master of the memory port while it is not waiting on the core.

## Interface
- `N`, 256: coefficients per job; power of two.
- `AW`, 8: memory address width, log2(N).
- `clk_i`  in  1  system clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `word_data_i`  in  32  received word.
- `word_addr_i`  in  32  target word address; only bits [AW-1:0] are used.
- `word_valid_i`  in  1  one-cycle strobe; word/addr valid.
- `load_done_i`  in  1  level; host stream complete.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  AW  memory address.
- `mem_wdata_o`  out  32  memory write data.
- `mem_rdata_i`  in  32  memory read data; 1-cycle synchronous read.
- `ntt_start_o`  out  1  one-cycle start pulse.
- `ntt_done_i`  in  1  core finished; level or pulse.
- `tx_byte_o`  out  8  byte to transmitter.
- `tx_valid_o`  out  1  byte valid.
- `tx_ready_i`  in  1  transmitter accepts when valid&ready.
- `busy_o`  out  1  high in any state except IDLE/FINISH.
- `err_o`  out  1  sticky error flag.

## Operation
- States: IDLE, LOAD, START, WAIT, RD_ADDR, RD_DATA, SEND, FINISH.
- IDLE: the first `word_valid_i` moves the FSM to LOAD and is processed like any other LOAD word.
- LOAD: each `word_valid_i` registers a write (`mem_we_o`=1, addr=`word_addr_i[AW-1:0]`, data=`word_data_i`) on the next cycle. `load_cnt` increments, saturating at N.
- Address check: if `word_addr_i[31:AW]`≠0, the write is suppressed and `err_o` is set.
- LOAD exit: `load_done_i`=1 goes to START. A `word_valid_i` in the same cycle is still written.
- START: `ntt_start_o`=1 for exactly one cycle, then WAIT.
- WAIT: the memory port is idle (`mem_we_o`=0). `ntt_done_i`=1 goes to RD_ADDR with `rd_idx`=0.
- RD_ADDR: drives `mem_addr_o`=`rd_idx`, then RD_DATA.
- RD_DATA: latches `mem_rdata_i` into the shift register, `byte_idx`=0, then SEND.
- SEND: `tx_byte_o`=shift[8*byte_idx+:8], little-endian with byte 0 first. `tx_valid_o`=1.
  - On `tx_ready_i`, `byte_idx`++.
  - After byte 3, if `rd_idx`=N-1 go to FINISH; else `rd_idx`++ and go to RD_ADDR.
- FINISH: holds until reset. `busy_o`=0.
- `word_valid_i` outside IDLE/LOAD is ignored and sets `err_o`.
- `load_done_i` in IDLE with zero words received is ignored.
- A job with fewer than N words loaded still runs. Unwritten locations keep their previous contents.

## Timing
- Reset values: all outputs 0. The FSM is in IDLE and all counters are 0.
- Reset mid-job aborts immediately: the next cycle is IDLE with `tx_valid_o`=0 and `mem_we_o`=0.
- Write latency: `word_valid_i` at cycle t gives `mem_we_o` at t+1. Back-to-back strobes give back-to-back writes.
- `load_done_i` at t gives `ntt_start_o` at t+1. If a strobe also arrives at t, its write occurs at t+1 as well.
- Readback per word: 2 cycles (RD_ADDR, RD_DATA) plus 4 accepted bytes.
- Readback minimum with `tx_ready_i` tied high: 6N cycles.
- TX handshake: `tx_byte_o` is stable while `tx_valid_o`=1 and `tx_ready_i`=0. `tx_valid_o` never drops without acceptance, except on reset.
- `rd_idx` is AW+1 bits wide so that reaching N is detectable without wrap.

## Configuration
- `NTT_CTRL_CHECKSUM_EN` defined:
  - After the last result word, the controller sends one extra word: the XOR of all N result words, little-endian, 4 bytes.
  - It enters FINISH only after that word's byte 3 is accepted.
  - The checksum accumulator is cleared on entry to RD_ADDR with `rd_idx`=0.
- Undefined: no checksum word. FINISH follows the last result byte, and no accumulator logic is present.

## Test plan
- Full job, N=8 build: 8 words with addr 0..7, data 0x11110000+i, then `load_done_i`.
  - Expect 8 writes and one `ntt_start_o` pulse.
  - Memory model returns data+1 after `ntt_done_i`.
  - Expect 32 bytes, first four 01 00 11 11.
- Out-of-range address: addr 0x00000100 with N=256 → no `mem_we_o`, `err_o`=1, job continues normally.
- Backpressure: `tx_ready_i` low for 5 cycles on byte 2 → `tx_byte_o` is held, and no byte is skipped or duplicated.
- Simultaneous events: last `word_valid_i` and `load_done_i` in the same cycle → that write and `ntt_start_o` both occur the next cycle.
- Reset mid-SEND: assert `rst_i` during byte 1 of word 3 → next cycle FSM is IDLE and all outputs are 0; a new job then restarts at address 0.
- `NTT_CTRL_CHECKSUM_EN`: results 0x1, 0x2, 0x4, …, N=8 → trailing word 0x000000FF sent as FF 00 00 00.
